// File: rtl/temp_window_ctrl.sv
// Window sequencer for the 14-deep temperature register file: paces ADC
// conversions from a tick divider and loads exactly N samples per window.
module temp_window_ctrl #(
    parameter int DIV_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [3:0]       N,
    input  logic [DIV_W-1:0] DIV,
    output logic             ADC_START,
    input  logic             ADC_DONE,
    input  logic [11:0]      ADC_DATA,
    output logic             RF_CLEAR,
    output logic             SAMPLE,
    output logic [11:0]      TN,
    output logic [3:0]       FILL,
    output logic             WINDOW_VALID,
    input  logic             ACK,
    output logic             OVERRUN,
    output logic             ADC_ERR
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WAIT_TICK,
        S_CONVERT,
        S_LOAD,
        S_READY
    } state_t;

    function automatic logic [3:0] clamp_n(input logic [3:0] n);
        return (n == 4'd0 || n > 4'd14) ? 4'd14 : n;
    endfunction

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;
    logic             tick;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       n_q;

    // ">=" keeps the divider sane if DIV is lowered while the counter is above it
    assign div_last = clamp_div(DIV) - DIV_W'(1);
    assign tick     = (div_cnt >= div_last);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            to_cnt       <= '0;
            n_q          <= 4'd14;
            ADC_START    <= 1'b0;
            SAMPLE       <= 1'b0;
            RF_CLEAR     <= 1'b0;
            TN           <= '0;
            FILL         <= '0;
            WINDOW_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
            ADC_ERR      <= 1'b0;
        end else begin
            ADC_START <= 1'b0;
            SAMPLE    <= 1'b0;
            RF_CLEAR  <= 1'b0;
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);

            if (!ENABLE) begin
                // abort: a partial window must never be summed, so clear the file
                state        <= S_IDLE;
                RF_CLEAR     <= (state != S_IDLE);
                div_cnt      <= '0;
                to_cnt       <= '0;
                FILL         <= '0;
                WINDOW_VALID <= 1'b0;
                OVERRUN      <= 1'b0;
                ADC_ERR      <= 1'b0;
            end else begin
                if (tick && (state == S_CONVERT || state == S_LOAD || state == S_READY))
                    OVERRUN <= 1'b1;

                case (state)
                    S_IDLE: begin
                        div_cnt  <= '0;
                        state    <= S_FLUSH;
                        RF_CLEAR <= 1'b1;
                        FILL     <= '0;
                    end
                    S_FLUSH: begin
                        div_cnt <= '0;
                        n_q     <= clamp_n(N);
                        state   <= S_WAIT_TICK;
                    end
                    S_WAIT_TICK: begin
                        if (tick) begin
                            state     <= S_CONVERT;
                            ADC_START <= 1'b1;
                            to_cnt    <= '0;
                        end
                    end
                    S_CONVERT: begin
                        // a done strobe on the last allowed cycle still counts
                        if (ADC_DONE) begin
                            TN     <= ADC_DATA;
                            SAMPLE <= 1'b1;
                            state  <= S_LOAD;
                        end else if (to_cnt == TO_LAST) begin
                            ADC_ERR <= 1'b1;
                            state   <= S_WAIT_TICK;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    S_LOAD: begin
                        FILL <= FILL + 4'd1;
                        if ((FILL + 4'd1) == n_q) begin
                            state        <= S_READY;
                            WINDOW_VALID <= 1'b1;
                        end else begin
                            state <= S_WAIT_TICK;
                        end
                    end
                    S_READY: begin
                        if (ACK) begin
                            state        <= S_FLUSH;
                            WINDOW_VALID <= 1'b0;
                            RF_CLEAR     <= 1'b1;
                            FILL         <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temp_window_ctrl.sv
// Scoreboard bench for temp_window_ctrl: an ADC responder feeds a window-level
// reference model, and a monitor checks SAMPLE / WINDOW_VALID / ADC_ERR events.
module tb_temp_window_ctrl;

    localparam int DIV_W   = 16;
    localparam int TIMEOUT = 255;

    logic             CLK = 1'b0;
    logic             RESET, ENABLE, ADC_DONE, ACK;
    logic [3:0]       N;
    logic [DIV_W-1:0] DIV;
    logic [11:0]      ADC_DATA;
    logic             ADC_START, RF_CLEAR, SAMPLE, WINDOW_VALID, OVERRUN, ADC_ERR;
    logic [11:0]      TN;
    logic [3:0]       FILL;

    temp_window_ctrl #(.DIV_W(DIV_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .N(N), .DIV(DIV),
        .ADC_START(ADC_START), .ADC_DONE(ADC_DONE), .ADC_DATA(ADC_DATA),
        .RF_CLEAR(RF_CLEAR), .SAMPLE(SAMPLE), .TN(TN), .FILL(FILL),
        .WINDOW_VALID(WINDOW_VALID), .ACK(ACK), .OVERRUN(OVERRUN), .ADC_ERR(ADC_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct { int data; int c; } samp_t;
    typedef struct { int len; longint sum; longint sq; int c; } win_t;

    int      cyc = 0;
    int      n_vec = 0;
    int      n_bad = 0;
    samp_t   exp_samples[$];
    win_t    exp_windows[$];
    int      exp_err[$];
    int      model_cur[$];
    int      model_len = 14;
    int      data_q[$];
    int      sample_log[$];
    int      resp_mode = 0;   // 0 normal, 1 withhold done, 2 deliver but expect it ignored
    int      lat_min = 1;
    int      lat_max = 6;
    int      rf[14];
    longint  rf_sum, rf_sq;

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
            $fatal(1);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: unexpected at cycle %0d", name, cyc);
    endtask

    function automatic int clampn(input int n);
        return (n == 0 || n > 14) ? 14 : n;
    endfunction

    // reference model: the window holds the first model_len accepted samples
    task automatic model_add(input int data, input int c);
        samp_t s;
        win_t  w;
        s.data = data;
        s.c    = c;
        exp_samples.push_back(s);
        model_cur.push_back(data);
        if (model_cur.size() == model_len) begin
            w.len = model_len;
            w.sum = 0;
            w.sq  = 0;
            foreach (model_cur[i]) begin
                w.sum += model_cur[i];
                w.sq  += longint'(model_cur[i]) * model_cur[i];
            end
            w.c = c + 1;
            exp_windows.push_back(w);
            model_cur.delete();
        end
    endtask

    // ADC responder
    initial begin
        ADC_DONE = 1'b0;
        ADC_DATA = '0;
        forever begin
            @(negedge CLK);
            if (ADC_START) begin
                automatic int s    = cyc;
                automatic int mode = resp_mode;
                resp_mode = 0;
                if (mode == 1) begin
                    exp_err.push_back(s + TIMEOUT);
                end else begin
                    automatic int lat  = $urandom_range(lat_max, lat_min);
                    automatic int data = (data_q.size() > 0) ? data_q.pop_front() : int'($urandom_range(4095, 0));
                    repeat (lat) @(posedge CLK);
                    #1;
                    ADC_DONE = 1'b1;
                    ADC_DATA = 12'(data);
                    if (mode == 0) model_add(data, cyc + 1);
                    @(posedge CLK);
                    #1;
                    ADC_DONE = 1'b0;
                    ADC_DATA = 12'($urandom);
                end
            end
        end
    end

    // monitor: register-file model plus scoreboard pops
    initial begin
        automatic logic wv_prev  = 1'b0;
        automatic logic err_prev = 1'b0;
        foreach (rf[i]) rf[i] = 0;
        rf_sum = 0;
        rf_sq  = 0;
        forever begin
            @(negedge CLK);
            if (RF_CLEAR) foreach (rf[i]) rf[i] = 0;
            if (SAMPLE) begin
                sample_log.push_back(cyc);
                if (exp_samples.size() == 0) begin
                    fail_event("sample_unexpected");
                end else begin
                    automatic samp_t e = exp_samples.pop_front();
                    check("sample_tn", TN, e.data);
                    check("sample_cycle", cyc, e.c);
                end
                for (int i = 13; i > 0; i--) rf[i] = rf[i-1];
                rf[0] = int'(TN);
            end
            rf_sum = 0;
            rf_sq  = 0;
            foreach (rf[i]) begin
                rf_sum += rf[i];
                rf_sq  += longint'(rf[i]) * rf[i];
            end
            if (WINDOW_VALID && !wv_prev) begin
                if (exp_windows.size() == 0) begin
                    fail_event("window_unexpected");
                end else begin
                    automatic win_t w = exp_windows.pop_front();
                    check("window_fill", FILL, w.len);
                    check("window_tsum", rf_sum, w.sum);
                    check("window_tsumsq", rf_sq, w.sq);
                    check("window_cycle", cyc, w.c);
                end
            end
            if (ADC_ERR && !err_prev) begin
                if (exp_err.size() == 0) fail_event("adc_err_unexpected");
                else check("adc_err_cycle", cyc, exp_err.pop_front());
            end
            wv_prev  = WINDOW_VALID;
            err_prev = ADC_ERR;
        end
    end

    task automatic wait_valid(input int max);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!WINDOW_VALID && k < max);
        if (!WINDOW_VALID) fail_event("wait_window_valid_timeout");
    endtask

    task automatic wait_start(input int max);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!ADC_START && k < max);
        if (!ADC_START) fail_event("wait_adc_start_timeout");
    endtask

    task automatic wait_fill(input int val, input int max);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (FILL != 4'(val) && k < max);
        if (FILL != 4'(val)) fail_event("wait_fill_timeout");
    endtask

    task automatic do_ack();
        @(posedge CLK);
        #1;
        ACK = 1'b1;
        model_len = clampn(int'(N));
        @(posedge CLK);
        #1;
        ACK = 1'b0;
    endtask

    initial begin
        int e, a;
        RESET  = 1'b1;
        ENABLE = 1'b0;
        ACK    = 1'b0;
        N      = 4'd4;
        DIV    = 16'd10;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_adc_start", ADC_START, 0);
        check("rst_sample", SAMPLE, 0);
        check("rst_rf_clear", RF_CLEAR, 0);
        check("rst_tn", TN, 0);
        check("rst_fill", FILL, 0);
        check("rst_window_valid", WINDOW_VALID, 0);
        check("rst_overrun", OVERRUN, 0);
        check("rst_adc_err", ADC_ERR, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // fixed window: N=4, DIV=10, latency 3, data 100..400
        data_q = '{100, 200, 300, 400};
        lat_min = 3;
        lat_max = 3;
        sample_log.delete();
        @(posedge CLK);
        #1;
        model_len = clampn(4);
        ENABLE = 1'b1;
        e = cyc;
        wait_valid(200);
        check("p1_sample_count", sample_log.size(), 4);
        if (sample_log.size() == 4) begin
            check("p1_first_sample", sample_log[0], e + 16);
            for (int i = 0; i < 3; i++) check("p1_sample_spacing", sample_log[i+1] - sample_log[i], 10);
        end
        check("p1_fill", FILL, 4);
        check("p1_tsum", rf_sum, 1000);
        check("p1_tsumsq", rf_sq, 300000);
        check("p1_no_overrun", OVERRUN, 0);

        // hold in READY: ticks become overruns, nothing loads
        repeat (50) @(negedge CLK);
        check("hold_overrun", OVERRUN, 1);
        check("hold_valid", WINDOW_VALID, 1);
        check("hold_samples", sample_log.size(), 4);
        check("hold_tsum", rf_sum, 1000);
        lat_min = 1;
        lat_max = 6;
        resp_mode = 1;
        do_ack();
        a = cyc - 1;
        @(negedge CLK);
        check("ack_rf_clear", RF_CLEAR, 1);
        check("ack_valid_low", WINDOW_VALID, 0);
        check("ack_fill", FILL, 0);
        check("ack_cycle", cyc, a + 1);
        @(negedge CLK);
        check("ack_tsum_cleared", rf_sum, 0);
        check("ack_rf_clear_pulse", RF_CLEAR, 0);

        // first conversion times out; window still gets 4 good samples
        wait_valid(2000);
        check("timeout_adc_err", ADC_ERR, 1);
        check("timeout_fill", FILL, 4);

        // N out of range clamps to 14
        N = 4'd0;
        do_ack();
        wait_valid(1000);
        check("n0_fill", FILL, 14);
        N = 4'd15;
        do_ack();
        wait_valid(1000);
        check("n15_fill", FILL, 14);

        // N change mid-window applies to the next window only
        N = 4'd4;
        do_ack();
        wait_fill(2, 200);
        N = 4'd2;
        wait_valid(200);
        check("nchg_cur_fill", FILL, 4);
        do_ack();
        wait_valid(200);
        check("nchg_next_fill", FILL, 2);

        // randomized windows
        for (int w = 0; w < 4; w++) begin
            DIV = DIV_W'($urandom_range(20, 8));
            lat_max = int'(DIV) - 3;
            N = 4'($urandom_range(15, 0));
            do_ack();
            wait_valid(1000);
            check("rand_fill", FILL, clampn(int'(N)));
        end

        // abort after 2 samples, late done must be ignored
        DIV = 16'd10;
        lat_min = 1;
        lat_max = 6;
        N = 4'd4;
        do_ack();
        wait_fill(2, 200);
        lat_min = 8;
        lat_max = 8;
        resp_mode = 2;
        wait_start(50);
        @(posedge CLK);
        #1;
        ENABLE = 1'b0;
        model_cur.delete();
        @(negedge CLK);
        @(negedge CLK);
        check("abort_rf_clear", RF_CLEAR, 1);
        check("abort_fill", FILL, 0);
        check("abort_overrun", OVERRUN, 0);
        check("abort_adc_err", ADC_ERR, 0);
        check("abort_valid", WINDOW_VALID, 0);
        @(negedge CLK);
        check("abort_rf_clear_pulse", RF_CLEAR, 0);
        repeat (10) @(negedge CLK);
        lat_min = 1;
        lat_max = 6;
        @(posedge CLK);
        #1;
        model_len = clampn(int'(N));
        ENABLE = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("reen_flush_clear", RF_CLEAR, 1);
        check("reen_fill", FILL, 0);
        wait_valid(300);
        check("reen_window_fill", FILL, 4);

        // reset during CONVERT
        lat_min = 5;
        lat_max = 5;
        resp_mode = 2;
        do_ack();
        wait_start(50);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_cur.delete();
        @(negedge CLK);
        @(negedge CLK);
        check("rstmid_adc_start", ADC_START, 0);
        check("rstmid_sample", SAMPLE, 0);
        check("rstmid_rf_clear", RF_CLEAR, 0);
        check("rstmid_tn", TN, 0);
        check("rstmid_fill", FILL, 0);
        check("rstmid_valid", WINDOW_VALID, 0);
        check("rstmid_overrun", OVERRUN, 0);
        check("rstmid_adc_err", ADC_ERR, 0);
        @(posedge CLK);
        #1;
        RESET  = 1'b0;
        ENABLE = 1'b0;
        repeat (10) @(negedge CLK);

        check("end_samples_pending", exp_samples.size(), 0);
        check("end_windows_pending", exp_windows.size(), 0);
        check("end_errs_pending", exp_err.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
